button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Input-side counterpart to the LED drivers: conditions the raw active-low iCEBreaker
//  user button BTN_N.
//  - Synchronises it, debounces it, and emits a clean level plus one-cycle press/release pulses.
//  - Keeps a wrapping press counter.
//  - Sits between the board button pin and the demo logic, e.g. to step LED patterns.
// PARAMETERS
//  DEBOUNCE_CYCLES  120000    stable cycles required to accept a level change (10 ms @ 12 MHz); >=2
//  LONG_CYCLES      12000000  held cycles after press acceptance that raise LONG_P (1 s @ 12 MHz)
//  CNT_W            8         width of PRESS_CNT
// PORTS
//  CLK        in   1      12 MHz system clock
//  RST_N      in   1      asynchronous active-low reset
//  BTN_N      in   1      raw button pin, active low, asynchronous to CLK, may bounce
//  PRESSED    out  1      debounced level, 1 = button held
//  PRESS_P    out  1      one-CLK pulse when a press is accepted
//  RELEASE_P  out  1      one-CLK pulse when a release is accepted
//  PRESS_CNT  out  CNT_W  number of accepted presses, modulo 2^CNT_W
//  LONG_P     out  1      one-CLK pulse on long press (constant 0 without LONG_PRESS_EN)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=RELEASED, counters 0, synchroniser flops set to 1 (released).
//  Input path: 2-FF synchroniser on BTN_N; btn = ~sync_q (active high internally).
//  FSM states: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
//  - RELEASED:     btn=1 -> PRESS_WAIT, db_cnt<=0.
//  - PRESS_WAIT:   btn=0 -> RELEASED, no pulse.
//                  btn=1 and db_cnt==DEBOUNCE_CYCLES-1 -> HELD, PRESS_P=1, PRESS_CNT+1;
//                  else db_cnt+1.
//  - HELD:         btn=0 -> RELEASE_WAIT, db_cnt<=0.
//  - RELEASE_WAIT: btn=1 -> HELD, no pulse.
//                  btn=0 and db_cnt==DEBOUNCE_CYCLES-1 -> RELEASED, RELEASE_P=1;
//                  else db_cnt+1.
//  PRESSED is registered: 1 in HELD and RELEASE_WAIT, 0 otherwise.
//  Latency: BTN_N low and stable from edge k -> PRESS_P and PRESSED high after edge
//  k+2+DEBOUNCE_CYCLES. Release is symmetric.
//  Any bounce shorter than DEBOUNCE_CYCLES: no pulse, PRESSED unchanged, db_cnt restarts on
//  the next change.
//  PRESS_P and RELEASE_P are never high in the same cycle, and never on consecutive press events
//  closer than 2*DEBOUNCE_CYCLES.
//  PRESS_CNT wraps 2^CNT_W-1 -> 0 silently.
//  Counter widths: db_cnt = $clog2(DEBOUNCE_CYCLES); hold counter = $clog2(LONG_CYCLES+1).
//  Button held through reset deassertion: a press is accepted DEBOUNCE_CYCLES+2 cycles later
//  (PRESS_P fires).
//  Reset asserted mid-debounce or mid-hold: immediate return to reset values, no pulses emitted.
// CONFIGURATION
//  LONG_PRESS_EN defined:
//  - A hold counter clears on entry to HELD and counts in HELD and RELEASE_WAIT.
//  - On reaching LONG_CYCLES, LONG_P pulses once; the counter saturates, so at most one
//    LONG_P per press.
//  - A bounce back to HELD does not clear the counter; re-entry from PRESS_WAIT does.
//  LONG_PRESS_EN undefined: no hold counter is built; LONG_P tied to 0.
// STRUCTURE
//  button_pkg: state typedef (btn_state_t, 2-bit enum of the four states).
//  button_pkg also holds constants SYNC_STAGES=2 and CLK_HZ=12000000.
//  Sub-module sync_2ff: generic 2-flop synchroniser with reset value parameter
//  (here 1), reused for other board inputs.
//  FSM, counters and outputs live in button_debounce.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=2)
//  1. Reset with BTN_N=1, idle 50 cycles.
//     -> all outputs 0, no pulses.
//  2. BTN_N=0 clean from edge 10.
//     -> PRESS_P=1 and PRESSED=1 after edge 16 only; PRESS_CNT=1.
//  3. BTN_N toggling every 2 cycles for 40 cycles, then stable 1.
//     -> no PRESS_P or RELEASE_P, PRESSED stays 0.
//  4. Five clean press/release pairs.
//     -> PRESS_CNT sequence 1,2,3,0,1; RELEASE_P once per release, 6 cycles after BTN_N high.
//  5. With LONG_PRESS_EN, hold 60 cycles including a 2-cycle bounce.
//     -> exactly one LONG_P, 20 cycles after PRESS_P.
//     Without the macro: LONG_P always 0.
//  6. RST_N low mid-PRESS_WAIT and mid-HELD.
//     -> outputs 0 at once, no pulse.
//     If BTN_N is still low after reset release, PRESS_P fires 6 cycles later.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and board constants for the user-button input path.
// No logic of its own; state encoding is shared with the debouncer.
package button_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int CLK_HZ      = 12000000;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs; reset value is a parameter.
// Latency: 2 clk_i edges; no backpressure.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces the active-low user button into a level, press/release pulses and a press count.
// Latency: 2 + DEBOUNCE_CYCLES edges per accepted change; no backpressure. LONG_PRESS_EN adds LONG_P.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000,
    parameter int CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             btn_n_i,
    output logic             pressed_o,
    output logic             press_p_o,
    output logic             release_p_o,
    output logic [CNT_W-1:0] press_cnt_o,
    output logic             long_p_o
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be at least 1");
    end

    btn_state_t       state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             pressed_q, pressed_d;
    logic             press_p_q, press_p_d;
    logic             release_p_q, release_p_d;
    logic             sync_n;
    logic             btn;

    // Reset value 1 keeps the synchroniser reading "released" until the pin is sampled.
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (btn_n_i),
        .q_o     (sync_n)
    );

    assign btn = ~sync_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RELEASED;
            db_cnt_q    <= '0;
            press_cnt_q <= '0;
            pressed_q   <= 1'b0;
            press_p_q   <= 1'b0;
            release_p_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            press_cnt_q <= press_cnt_d;
            pressed_q   <= pressed_d;
            press_p_q   <= press_p_d;
            release_p_q <= release_p_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        press_cnt_d = press_cnt_q;
        press_p_d   = 1'b0;
        release_p_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (btn) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn) begin
                    state_d = ST_RELEASED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_HELD;
                    press_p_d   = 1'b1;
                    press_cnt_d = press_cnt_q + CNT_W'(1);
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_HELD: begin
                if (!btn) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_RELEASED;
                    release_p_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = ST_RELEASED;
        endcase
        pressed_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    end

    assign pressed_o   = pressed_q;
    assign press_p_o   = press_p_q;
    assign release_p_o = release_p_q;
    assign press_cnt_o = press_cnt_q;

`ifdef LONG_PRESS_EN
    localparam int                HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_p_q, long_p_d;

    // Only a fresh acceptance clears the count; a release bounce back into HELD keeps it.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_p_d   = 1'b0;
        if (state_q == ST_PRESS_WAIT && state_d == ST_HELD) begin
            hold_cnt_d = '0;
        end else if ((state_q == ST_HELD || state_q == ST_RELEASE_WAIT) &&
                     hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            long_p_d   = (hold_cnt_d == HOLD_MAX);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_cnt_q <= '0;
            long_p_q   <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_p_q   <= long_p_d;
        end
    end

    assign long_p_o = long_p_q;
`else
    assign long_p_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=2.
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 20;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         btn_n;
    logic         pressed_o;
    logic         press_p_o;
    logic         release_p_o;
    logic [W-1:0] press_cnt_o;
    logic         long_p_o;

    int checks   = 0;
    int failures = 0;
    int n_press, n_release, n_long, n_unpressed, long_t, t_now;
    int exp_cnt [5] = '{1, 2, 3, 0, 1};

    button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .CNT_W           (W)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .btn_n_i     (btn_n),
        .pressed_o   (pressed_o),
        .press_p_o   (press_p_o),
        .release_p_o (release_p_o),
        .press_cnt_o (press_cnt_o),
        .long_p_o    (long_p_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample on the falling edge, tallying pulses seen.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        t_now++;
        if (press_p_o)   n_press++;
        if (release_p_o) n_release++;
        if (long_p_o) begin
            n_long++;
            long_t = t_now;
        end
        if (!pressed_o)  n_unpressed++;
    endtask

    task automatic clr();
        n_press     = 0;
        n_release   = 0;
        n_long      = 0;
        n_unpressed = 0;
        long_t      = -1;
        t_now       = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        btn_n = 1'b1;
        clr();
        @(negedge clk);
        chk("rst_pressed",   32'(pressed_o),   0);
        chk("rst_press_p",   32'(press_p_o),   0);
        chk("rst_release_p", 32'(release_p_o), 0);
        chk("rst_cnt",       32'(press_cnt_o), 0);
        chk("rst_long_p",    32'(long_p_o),    0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Idle with the button released.
        clr();
        repeat (50) cyc();
        chk("idle_press",   32'(n_press),     0);
        chk("idle_release", 32'(n_release),   0);
        chk("idle_pressed", 32'(n_unpressed), 50);
        chk("idle_cnt",     32'(press_cnt_o), 0);

        // Clean press: visible after the 7th edge following the pin change.
        clr();
        btn_n = 1'b0;
        repeat (6) cyc();
        chk("press_early_pulse",   32'(n_press),     0);
        chk("press_early_pressed", 32'(n_unpressed), 6);
        cyc();
        chk("press_pulse",   32'(press_p_o),   1);
        chk("press_pressed", 32'(pressed_o),   1);
        chk("press_cnt",     32'(press_cnt_o), 1);
        cyc();
        chk("press_pulse_one", 32'(press_p_o), 0);
        chk("press_hold",      32'(pressed_o), 1);
        btn_n = 1'b1;
        repeat (6) cyc();
        chk("release_early", 32'(n_release), 0);
        chk("release_level", 32'(pressed_o), 1);
        cyc();
        chk("release_pulse",   32'(release_p_o), 1);
        chk("release_pressed", 32'(pressed_o),   0);

        // Bounce: 2-cycle toggling never satisfies the debounce window.
        clr();
        for (int i = 0; i < 20; i++) begin
            btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc();
            cyc();
        end
        btn_n = 1'b1;
        repeat (10) cyc();
        chk("bounce_press",   32'(n_press),     0);
        chk("bounce_release", 32'(n_release),   0);
        chk("bounce_pressed", 32'(n_unpressed), 50);
        chk("bounce_cnt",     32'(press_cnt_o), 1);

        // Five press/release pairs from a cleared counter; CNT_W=2 wraps.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        clr();
        for (int i = 0; i < 5; i++) begin
            btn_n = 1'b0;
            repeat (6) cyc();
            chk("pair_early", 32'(press_p_o), 0);
            cyc();
            chk("pair_press", 32'(press_p_o),   1);
            chk("pair_cnt",   32'(press_cnt_o), 32'(exp_cnt[i]));
            repeat (3) cyc();
            btn_n = 1'b1;
            repeat (6) cyc();
            chk("pair_rel_early", 32'(release_p_o), 0);
            cyc();
            chk("pair_release", 32'(release_p_o), 1);
        end
        chk("pairs_press_total",   32'(n_press),   5);
        chk("pairs_release_total", 32'(n_release), 5);

        // Long hold with a 2-cycle release bounce in the middle.
        clr();
        btn_n = 1'b0;
        repeat (7) cyc();
        chk("long_press", 32'(press_p_o), 1);
        clr();
        for (int t = 1; t < 60; t++) begin
            if (t == 8)  btn_n = 1'b1;
            if (t == 10) btn_n = 1'b0;
            cyc();
        end
`ifdef LONG_PRESS_EN
        chk("long_count", 32'(n_long), 1);
        chk("long_time",  32'(long_t), 20);
`else
        chk("long_count", 32'(n_long), 0);
`endif
        chk("long_pressed", 32'(n_unpressed), 0);
        chk("long_release", 32'(n_release),   0);
        btn_n = 1'b1;
        repeat (7) cyc();
        chk("long_rel_pulse", 32'(n_release), 1);
        chk("long_rel_level", 32'(pressed_o), 0);

        // Reset in the middle of PRESS_WAIT with the button kept down.
        clr();
        btn_n = 1'b0;
        repeat (4) cyc();
        chk("pw_pre_cnt", 32'(press_cnt_o), 2);
        rst_n = 1'b0;
        #1;
        chk("pw_rst_pressed", 32'(pressed_o),   0);
        chk("pw_rst_press_p", 32'(press_p_o),   0);
        chk("pw_rst_cnt",     32'(press_cnt_o), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        clr();
        repeat (6) cyc();
        chk("pw_after_early", 32'(n_press), 0);
        cyc();
        chk("pw_after_press", 32'(press_p_o),   1);
        chk("pw_after_cnt",   32'(press_cnt_o), 1);

        // Reset in the middle of HELD, then release the button while in reset.
        repeat (5) cyc();
        chk("held_pre_pressed", 32'(pressed_o), 1);
        rst_n = 1'b0;
        #1;
        chk("held_rst_pressed", 32'(pressed_o),   0);
        chk("held_rst_cnt",     32'(press_cnt_o), 0);
        chk("held_rst_release", 32'(release_p_o), 0);
        btn_n = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        clr();
        repeat (20) cyc();
        chk("held_after_press",   32'(n_press),   0);
        chk("held_after_release", 32'(n_release), 0);
        chk("held_after_long",    32'(n_long),    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
